// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller.
//   - PWM_WIDTH_DEF : default width of counter, duty and target
//   - PWM_STEP_DEF  : default duty change applied per counter period
//   - pwm_state_e   : controller state encoding
package pwm_ctrl_pkg;

    localparam int PWM_WIDTH_DEF = 8;
    localparam int PWM_STEP_DEF  = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAMP     = 2'd1,
        ST_HOLD     = 2'd2,
        ST_STOPPING = 2'd3
    } pwm_state_e;

endpackage

// File: rtl/pwm_ramp_timebase.sv
// Free-running PWM timebase.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, clears the counter
//   count - current counter value, wraps from all-ones to zero
//   wrap  - high in the cycle where count is all-ones
module pwm_ramp_timebase
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next counter value; natural overflow gives the wrap to zero.
    always_comb begin
        count_d = count_q + CNT_ONE;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign wrap  = (count_q == CNT_MAX);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator whose duty ramps toward an accepted target, one STEP per
// counter period, with a controlled shutdown on stop.
// Build option: define PWM_RAMP_SOFTSTOP_EN to ramp duty down to zero on
// stop; otherwise duty drops to zero at the next counter wrap.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   tgt_valid - a new duty target is offered
//   tgt_data  - offered duty target
//   tgt_ready - a target is accepted this cycle (IDLE or HOLD)
//   stop      - request PWM shutdown (wins over a same-cycle target)
//   duty      - current duty setpoint
//   count     - free-running timebase value
//   pwm_out   - registered (duty > count)
//   busy      - state is not IDLE
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEF,
    parameter int STEP  = PWM_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic             stop,
    output logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] count,
    output logic             pwm_out,
    output logic             busy
);

    // One extra bit keeps the step arithmetic free of wrap-around.
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    // Move cur one STEP toward tgt, landing exactly on tgt when closer than STEP.
    function automatic logic [WIDTH-1:0] ramp_step(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] cur_x;
        logic [WIDTH:0] tgt_x;
        logic [WIDTH:0] res_x;
        cur_x = {1'b0, cur};
        tgt_x = {1'b0, tgt};
        if (tgt_x > cur_x) begin
            res_x = cur_x + STEP_X;
            if (res_x > tgt_x) begin
                res_x = tgt_x;
            end else begin
                res_x = res_x;
            end
        end else begin
            if ((cur_x - tgt_x) > STEP_X) begin
                res_x = cur_x - STEP_X;
            end else begin
                res_x = tgt_x;
            end
        end
        return res_x[WIDTH-1:0];
    endfunction

    pwm_state_e       state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             pwm_q, pwm_d;

    logic [WIDTH-1:0] count_s;
    logic             wrap_s;
    logic             ready_s;
    logic             xfer_s;
    logic [WIDTH-1:0] ramp_nxt_s;
    logic [WIDTH-1:0] stop_nxt_s;

    pwm_ramp_timebase #(
        .WIDTH (WIDTH)
    ) u_timebase (
        .clk   (clk),
        .rst   (rst),
        .count (count_s),
        .wrap  (wrap_s)
    );

    assign ready_s    = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign xfer_s     = tgt_valid && ready_s;
    assign ramp_nxt_s = ramp_step(duty_q, target_q);
    // Shutdown uses the same stepping toward a target of zero.
    assign stop_nxt_s = ramp_step(duty_q, {WIDTH{1'b0}});

    // Next-state, duty and target update.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    target_d = tgt_data;
                    state_d  = (tgt_data != duty_q) ? ST_RAMP : ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_STOPPING;
                end else if (xfer_s) begin
                    target_d = tgt_data;
                    state_d  = (tgt_data != duty_q) ? ST_RAMP : ST_HOLD;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RAMP: begin
                if (stop) begin
                    state_d = ST_STOPPING;
                end else if (wrap_s) begin
                    duty_d  = ramp_nxt_s;
                    state_d = (ramp_nxt_s == target_q) ? ST_HOLD : ST_RAMP;
                end else begin
                    state_d = ST_RAMP;
                end
            end
            ST_STOPPING: begin
                if (wrap_s) begin
`ifdef PWM_RAMP_SOFTSTOP_EN
                    duty_d  = stop_nxt_s;
                    state_d = (stop_nxt_s == {WIDTH{1'b0}}) ? ST_IDLE : ST_STOPPING;
`else
                    duty_d  = {WIDTH{1'b0}};
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_STOPPING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // PWM compare; registered below for a one-cycle latency.
    always_comb begin
        pwm_d = (duty_q > count_s) ? 1'b1 : 1'b0;
    end

    // Controller registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            duty_q   <= {WIDTH{1'b0}};
            target_q <= {WIDTH{1'b0}};
            pwm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            pwm_q    <= pwm_d;
        end
    end

    assign tgt_ready = ready_s;
    assign duty      = duty_q;
    assign count     = count_s;
    assign pwm_out   = pwm_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl with WIDTH=8, STEP=16.
module tb_pwm_ramp_ctrl;

    logic       clk;
    logic       rst;
    logic       tgt_valid;
    logic [7:0] tgt_data;
    logic       tgt_ready;
    logic       stop;
    logic [7:0] duty;
    logic [7:0] count;
    logic       pwm_out;
    logic       busy;

    int n_pass;
    int n_total;

    typedef struct {
        string      nm;
        logic [7:0] duty;
        logic       busy;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];

    pwm_ramp_ctrl #(
        .WIDTH (8),
        .STEP  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_data  (tgt_data),
        .tgt_ready (tgt_ready),
        .stop      (stop),
        .duty      (duty),
        .count     (count),
        .pwm_out   (pwm_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [7:0] d, input logic b, input logic r);
        exp_t e;
        e.nm    = nm;
        e.duty  = d;
        e.busy  = b;
        e.ready = r;
        exp_q.push_back(e);
    endtask

    // The first cycle after each wrap (count==0) presents a new duty period.
    always @(negedge clk) begin
        if (!rst && count == 8'd0 && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.nm, "_duty"},  {24'd0, duty}, {24'd0, e.duty});
            check({e.nm, "_busy"},  {31'd0, busy}, {31'd0, e.busy});
            check({e.nm, "_ready"}, {31'd0, tgt_ready}, {31'd0, e.ready});
        end
    end

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic offer(input logic [7:0] d);
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_data  = d;
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
    endtask

    initial begin
        int hi;
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        stop      = 1'b0;
        tgt_valid = 1'b1;
        tgt_data  = 8'h55;

        // Reset with a handshake offered: must be ignored.
        repeat (3) @(negedge clk);
        check("rst_duty",  {24'd0, duty},  32'd0);
        check("rst_count", {24'd0, count}, 32'd0);
        check("rst_pwm",   {31'd0, pwm_out}, 32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        tgt_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_duty", {24'd0, duty}, 32'd0);

        // Ramp 0 -> 0x40.
        @(negedge clk);
        check("idle_ready", {31'd0, tgt_ready}, 32'd1);
        offer(8'h40);
        check("ramp_busy",  {31'd0, busy},      32'd1);
        check("ramp_ready", {31'd0, tgt_ready}, 32'd0);
        push("ramp1", 8'h10, 1'b1, 1'b0);
        push("ramp2", 8'h20, 1'b1, 1'b0);
        push("ramp3", 8'h30, 1'b1, 1'b0);
        push("ramp4", 8'h40, 1'b1, 1'b1);
        wait_drain(256 * 5);

        // One full PWM period at duty 0x40, starting at count==0.
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (count == 8'd0) check("pwm_at_cnt0", {31'd0, pwm_out}, 32'd0);
            if (count == 8'd1) check("pwm_rise",    {31'd0, pwm_out}, 32'd1);
            if (count == 8'd65) check("pwm_fall",   {31'd0, pwm_out}, 32'd0);
            hi += int'(pwm_out);
            @(negedge clk);
            #1;
        end
        check("pwm_high_cycles", hi, 32'd64);

        // Clamped ramp 0x40 -> 0x45, then same target goes straight to HOLD.
        offer(8'h45);
        check("clamp_ready", {31'd0, tgt_ready}, 32'd0);
        push("clamp", 8'h45, 1'b1, 1'b1);
        wait_drain(256 * 2);
        offer(8'h45);
        check("same_tgt_busy",  {31'd0, busy},      32'd1);
        check("same_tgt_ready", {31'd0, tgt_ready}, 32'd1);
        check("same_tgt_duty",  {24'd0, duty},      32'h45);
        push("same_tgt_hold", 8'h45, 1'b1, 1'b1);
        wait_drain(256 * 2);
        offer(8'h40);
        push("down_clamp", 8'h40, 1'b1, 1'b1);
        wait_drain(256 * 2);

        // Stop and a target in the same cycle: stop wins.
        @(negedge clk);
        stop      = 1'b1;
        tgt_valid = 1'b1;
        tgt_data  = 8'h80;
        @(posedge clk);
        #1;
        stop      = 1'b0;
        tgt_valid = 1'b0;
        check("stopping_busy",  {31'd0, busy},      32'd1);
        check("stopping_ready", {31'd0, tgt_ready}, 32'd0);
`ifdef PWM_RAMP_SOFTSTOP_EN
        push("soft1", 8'h30, 1'b1, 1'b0);
        push("soft2", 8'h20, 1'b1, 1'b0);
        push("soft3", 8'h10, 1'b1, 1'b0);
        push("soft4", 8'h00, 1'b0, 1'b1);
`else
        push("hard", 8'h00, 1'b0, 1'b1);
`endif
        push("stopped_idle", 8'h00, 1'b0, 1'b1);
        wait_drain(256 * 7);

        // Stop in IDLE does nothing.
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("idle_stop_busy", {31'd0, busy}, 32'd0);

        // Ramp to 0x40 while a 0x00 target is held waiting for ready.
        offer(8'h40);
        tgt_valid = 1'b1;
        tgt_data  = 8'h00;
        push("hold1", 8'h10, 1'b1, 1'b0);
        push("hold2", 8'h20, 1'b1, 1'b0);
        push("hold3", 8'h30, 1'b1, 1'b0);
        push("hold4", 8'h40, 1'b1, 1'b1);
        for (int i = 0; i < 256 * 5; i++) begin
            @(negedge clk);
            #1;
            if (tgt_ready && exp_q.size() == 0) break;
        end
        check("held_wait", {31'd0, tgt_ready}, 32'd1);
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
        check("held_xfer_busy",  {31'd0, busy},      32'd1);
        check("held_xfer_ready", {31'd0, tgt_ready}, 32'd0);
        push("rdown1", 8'h30, 1'b1, 1'b0);
        push("rdown2", 8'h20, 1'b1, 1'b0);
        wait_drain(256 * 3);

        // Async reset mid-RAMP at duty 0x20 while pwm_out is high.
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_pwm", {31'd0, pwm_out}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_duty",  {24'd0, duty},    32'd0);
        check("async_rst_count", {24'd0, count},   32'd0);
        check("async_rst_pwm",   {31'd0, pwm_out}, 32'd0);
        check("async_rst_busy",  {31'd0, busy},    32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("release_count0", {24'd0, count}, 32'd0);
        @(posedge clk);
        #1;
        check("release_count1", {24'd0, count}, 32'd1);
        check("release_busy",   {31'd0, busy},  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
